// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window buffer: pixel and 3x3 window
// types, plus the conversion of a window into the flat output bus.
package sobel_pkg;

    // Grayscale sample width used throughout the Sobel datapath.
    localparam int unsigned PIXEL_WIDTH = 8;

    // Neighbourhood edge length and flat bus width for one window.
    localparam int unsigned WIN_DIM  = 3;
    localparam int unsigned WIN_BITS = WIN_DIM * WIN_DIM * PIXEL_WIDTH;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    // Indexed [row][col]; row 0 is the oldest line (top), row 2 the current line.
    typedef pixel_t [WIN_DIM-1:0][WIN_DIM-1:0] window_t;

    // One vertical slice of the neighbourhood, index 0 = top row.
    typedef pixel_t [WIN_DIM-1:0] column_t;

    typedef logic [WIN_BITS-1:0] win_bus_t;

    // Flatten a window so that element (r,c) lands at [PIXEL_WIDTH*(3*r+c) +: PIXEL_WIDTH].
    function automatic win_bus_t pack_window(input window_t w);
        win_bus_t bus;
        bus = '0;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM; c++) begin
                bus[PIXEL_WIDTH*(WIN_DIM*r+c) +: PIXEL_WIDTH] = w[r][c];
            end
        end
        return bus;
    endfunction

    // Slide the window one column left and insert a fresh right-hand column.
    function automatic window_t shift_in_column(input window_t w, input column_t col);
        window_t nxt;
        nxt = w;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM - 1; c++) begin
                nxt[r][c] = w[r][c+1];
            end
            nxt[r][WIN_DIM-1] = col[r];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: a single synchronous write port and an
// asynchronous read port sharing the same address, so a location can be read
// (old value) and overwritten (new value) in the same cycle.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [PIXEL_WIDTH-1:0] wdata_i,
    output logic [PIXEL_WIDTH-1:0] rdata_o
);

    pixel_t mem_q [DEPTH];

    // Line storage write; the read below returns the pre-write contents.
    // NOTE: the storage array deliberately has no reset; every location is
    // rewritten before it can reach an emitted window, and leaving it out
    // keeps the array mappable onto plain RAM/LUT storage.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_buffer.sv
// Sobel window buffer: turns a raster-order pixel stream into 3x3
// neighbourhoods for every interior pixel of the frame. Two line buffers hold
// the previous two lines; a 3x3 register window slides right on every accepted
// pixel. Output uses a valid/ready handshake that stalls the input when full.
module sobel_window_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned IMG_HEIGHT = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic [PIXEL_WIDTH-1:0] px_i,
    input  logic                   px_valid_i,
    output logic                   px_ready_o,
    output logic [WIN_BITS-1:0]    win_o,
    output logic                   win_valid_o,
    input  logic                   win_ready_i,
    output logic                   win_last_o,
    output logic                   frame_done_o
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_INTERIOR = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_INTERIOR = ROW_W'(2);

    // Raster position of the next pixel to be accepted.
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Sliding neighbourhood and output handshake state.
    window_t window_q, window_d;
    logic    win_valid_q, win_valid_d;
    logic    win_last_q, win_last_d;
    logic    frame_done_q, frame_done_d;

    // Line buffer read data: line A holds row-1, line B holds row-2.
    pixel_t  line_a_rd;
    pixel_t  line_b_rd;
    column_t new_col;

    logic accept;
    logic col_end;
    logic row_end;
    logic frame_end;
    logic emit;

    // The output register can take a new window when empty or being drained.
    assign px_ready_o = !win_valid_q || win_ready_i;

    // Clear and reset both swallow any pixel presented alongside them.
    assign accept = px_valid_i && px_ready_o && !clear_i && !reset_i;

    assign col_end   = (col_q == COL_LAST);
    assign row_end   = (row_q == ROW_LAST);
    assign frame_end = col_end && row_end;

    // Only pixels with two full lines and two full columns behind them complete
    // a window; the window is centred one row up and one column left.
    assign emit = accept && (row_q >= ROW_FIRST_INTERIOR) && (col_q >= COL_FIRST_INTERIOR);

    // Column entering the window: oldest line on top, incoming pixel at the bottom.
    assign new_col = {px_i, line_a_rd, line_b_rd};

    // Line A receives the incoming pixel and hands its previous content to line B.
    sobel_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (COL_W)
    ) u_line_a (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (px_i),
        .rdata_o (line_a_rd)
    );

    sobel_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (COL_W)
    ) u_line_b (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (line_a_rd),
        .rdata_o (line_b_rd)
    );

    // Raster counters: advance on accept, wrap at line and frame ends.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Window shift: every accepted pixel, border or not, pushes a column in.
    always_comb begin
        window_d = window_q;
        if (clear_i) begin
            window_d = '0;
        end else if (accept) begin
            window_d = shift_in_column(window_q, new_col);
        end
    end

    // Output handshake: load on emit, drop on consume, otherwise hold.
    always_comb begin
        win_valid_d  = win_valid_q;
        win_last_d   = win_last_q;
        frame_done_d = 1'b0;
        if (clear_i) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end else begin
            if (emit) begin
                win_valid_d = 1'b1;
                win_last_d  = frame_end;
            end else if (win_ready_i) begin
                win_valid_d = 1'b0;
                win_last_d  = 1'b0;
            end
            frame_done_d = accept && frame_end;
        end
    end

    // State registers with synchronous reset.
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q        <= '0;
            row_q        <= '0;
            window_q     <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            window_q     <= window_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_o        = pack_window(window_q);
    assign win_valid_o  = win_valid_q;
    assign win_last_o   = win_last_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Bench for sobel_window_buffer: a 4x4 instance for directed sequences and a
// 16x16 instance for random traffic. A frame-image reference model watches
// both instances every cycle and checks handshake, windows and pulses.
module tb_sobel_window_buffer;
    import sobel_pkg::*;

    localparam int PW = PIXEL_WIDTH;
    localparam int WB = 9 * PW;

    localparam logic [WB-1:0] FIRST_WIN  = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    localparam logic [WB-1:0] LAST_WIN   = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
    localparam logic [WB-1:0] FRAME2_WIN = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small (4x4) instance signals.
    logic          s_rst, s_clr, s_pv, s_pr, s_wv, s_wr, s_wl, s_fd;
    logic [PW-1:0] s_px;
    logic [WB-1:0] s_wo;

    // Large (16x16) instance signals.
    logic          b_rst, b_clr, b_pv, b_pr, b_wv, b_wr, b_wl, b_fd;
    logic [PW-1:0] b_px;
    logic [WB-1:0] b_wo;

    int errors = 0;
    int checks = 0;

    sobel_window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_small (
        .clk_i(clk), .reset_i(s_rst), .clear_i(s_clr), .px_i(s_px),
        .px_valid_i(s_pv), .px_ready_o(s_pr), .win_o(s_wo), .win_valid_o(s_wv),
        .win_ready_i(s_wr), .win_last_o(s_wl), .frame_done_o(s_fd)
    );

    sobel_window_buffer #(.IMG_WIDTH(16), .IMG_HEIGHT(16)) dut_big (
        .clk_i(clk), .reset_i(b_rst), .clear_i(b_clr), .px_i(b_px),
        .px_valid_i(b_pv), .px_ready_o(b_pr), .win_o(b_wo), .win_valid_o(b_wv),
        .win_ready_i(b_wr), .win_last_o(b_wl), .frame_done_o(b_fd)
    );

    task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: the current frame image, raster position of the next
    // pixel, and a queue of windows produced but not yet consumed.
    logic [PW-1:0] img [2][16][16];
    int            pos [2];
    logic [WB-1:0] qw  [2][64];
    logic          ql  [2][64];
    int            qh  [2];
    int            qt  [2];
    logic          fd_exp [2];
    logic          rst_prev [2];
    int            win_cnt [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; qh[i] = 0; qt[i] = 0;
            fd_exp[i] = 1'b0; rst_prev[i] = 1'b0; win_cnt[i] = 0;
        end
    end

    task automatic model_step(input int id, input int w, input int h,
                              input logic rst, input logic clr, input logic pv,
                              input logic [PW-1:0] px, input logic pr, input logic wv,
                              input logic [WB-1:0] wo, input logic wl, input logic wr,
                              input logic fd);
        string         tag;
        logic          mvalid;
        int            r, c;
        logic [WB-1:0] nw;
        tag    = (id == 0) ? "small" : "big";
        mvalid = (qt[id] - qh[id]) > 0;
        if (rst_prev[id]) begin
            check($sformatf("%s_rst_win", tag), wo, '0);
            check($sformatf("%s_rst_valid", tag), wv, 1'b0);
            check($sformatf("%s_rst_last", tag), wl, 1'b0);
            check($sformatf("%s_rst_done", tag), fd, 1'b0);
        end else begin
            check($sformatf("%s_valid", tag), wv, mvalid);
            if (mvalid) begin
                check($sformatf("%s_win", tag), wo, qw[id][qh[id] % 64]);
                check($sformatf("%s_last", tag), wl, ql[id][qh[id] % 64]);
            end
            check($sformatf("%s_done", tag), fd, fd_exp[id]);
        end
        check($sformatf("%s_ready", tag), pr, !mvalid || wr);

        if (rst || clr) begin
            qh[id] = qt[id];
            pos[id] = 0;
            fd_exp[id] = 1'b0;
            rst_prev[id] = 1'b1;
        end else begin
            rst_prev[id] = 1'b0;
            fd_exp[id] = 1'b0;
            if (mvalid && wr) begin
                qh[id]++;
                win_cnt[id]++;
            end
            if (pv && (!mvalid || wr)) begin
                r = pos[id] / w;
                c = pos[id] % w;
                img[id][r][c] = px;
                if (r >= 2 && c >= 2) begin
                    nw = '0;
                    for (int a = 0; a < 3; a++)
                        for (int b = 0; b < 3; b++)
                            nw[PW*(3*a+b) +: PW] = img[id][r-2+a][c-2+b];
                    qw[id][qt[id] % 64] = nw;
                    ql[id][qt[id] % 64] = (pos[id] == w*h - 1);
                    qt[id]++;
                end
                fd_exp[id] = (pos[id] == w*h - 1);
                pos[id] = (pos[id] + 1) % (w*h);
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 4, 4, s_rst, s_clr, s_pv, s_px, s_pr, s_wv, s_wo, s_wl, s_wr, s_fd);
        model_step(1, 16, 16, b_rst, b_clr, b_pv, b_px, b_pr, b_wv, b_wo, b_wl, b_wr, b_fd);
    end

    // ---------------- directed helpers ----------------
    // Window of a 4-wide frame whose pixel values equal their raster index.
    function automatic logic [WB-1:0] idx_win(input int r, input int c, input int w);
        logic [WB-1:0] v;
        v = '0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                v[PW*(3*a+b) +: PW] = PW'((r-2+a)*w + (c-2+b));
        return v;
    endfunction

    // Present one pixel to the small instance; returns at posedge+1 after it was taken.
    task automatic send_s(input logic [PW-1:0] v);
        logic accepted;
        accepted = 1'b0;
        s_px = v;
        s_pv = 1'b1;
        for (int k = 0; k < 64 && !accepted; k++) begin
            #1;
            accepted = s_pr;
            @(posedge clk);
            #1;
        end
        s_pv = 1'b0;
        check("send_accepted", accepted, 1'b1);
    endtask

    task automatic send_frame_s(input int base);
        for (int i = 0; i < 16; i++) send_s(PW'(base + i));
    endtask

    typedef struct {
        logic [PW-1:0] px;
        logic          exp_valid;
        logic [WB-1:0] exp_win;
        logic          exp_last;
        logic          exp_done;
    } vec_t;

    vec_t tbl [16];

    // ---------------- main sequence ----------------
    initial begin
        int cnt0;
        int acc;
        int cyc;

        for (int i = 0; i < 16; i++) begin
            tbl[i].px        = PW'(i);
            tbl[i].exp_valid = (i / 4 >= 2) && (i % 4 >= 2);
            tbl[i].exp_win   = tbl[i].exp_valid ? idx_win(i / 4, i % 4, 4) : '0;
            tbl[i].exp_last  = (i == 15);
            tbl[i].exp_done  = (i == 15);
        end

        s_rst = 1'b1; s_clr = 1'b0; s_pv = 1'b0; s_px = '0; s_wr = 1'b1;
        b_rst = 1'b1; b_clr = 1'b0; b_pv = 1'b0; b_px = '0; b_wr = 1'b1;
        @(posedge clk); #1;
        check("reset_small_valid", s_wv, 1'b0);
        check("reset_small_win", s_wo, '0);
        check("reset_big_valid", b_wv, 1'b0);
        @(posedge clk); #1;
        s_rst = 1'b0; b_rst = 1'b0;
        #1;
        check("reset_small_ready", s_pr, 1'b1);
        check("reset_big_ready", b_pr, 1'b1);
        @(posedge clk); #1;

        // Table-driven frame 0..15 with consumer always ready.
        cnt0 = win_cnt[0];
        for (int i = 0; i < 16; i++) begin
            send_s(tbl[i].px);
            check($sformatf("tbl%0d_valid", i), s_wv, tbl[i].exp_valid);
            check($sformatf("tbl%0d_done", i), s_fd, tbl[i].exp_done);
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d_win", i), s_wo, tbl[i].exp_win);
                check($sformatf("tbl%0d_last", i), s_wl, tbl[i].exp_last);
            end
            if (i == 10) check("first_win_literal", s_wo, FIRST_WIN);
            if (i == 15) check("last_win_literal", s_wo, LAST_WIN);
        end
        @(posedge clk); #1;
        check("frame_win_count", 32'(win_cnt[0] - cnt0), 32'd4);

        // Consumer stall for 5 cycles after the first window.
        cnt0 = win_cnt[0];
        for (int i = 0; i <= 10; i++) send_s(PW'(i));
        s_wr = 1'b0;
        s_px = PW'(11);
        s_pv = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_ready_low", s_pr, 1'b0);
            check("stall_win_stable", s_wo, FIRST_WIN);
            check("stall_valid_held", s_wv, 1'b1);
            @(posedge clk); #1;
        end
        s_wr = 1'b1;
        for (int i = 11; i < 16; i++) send_s(PW'(i));
        @(posedge clk); #1;
        check("stall_win_count", 32'(win_cnt[0] - cnt0), 32'd4);

        // Two back-to-back frames.
        cnt0 = win_cnt[0];
        send_frame_s(0);
        for (int i = 0; i <= 10; i++) send_s(PW'(100 + i));
        check("frame2_first_win", s_wo, FRAME2_WIN);
        for (int i = 11; i < 16; i++) send_s(PW'(100 + i));
        @(posedge clk); #1;
        check("b2b_win_count", 32'(win_cnt[0] - cnt0), 32'd8);

        // Reset after 9 pixels, then a clean frame.
        for (int i = 0; i < 9; i++) send_s(PW'(50 + i));
        s_rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_valid", s_wv, 1'b0);
        check("midreset_win", s_wo, '0);
        check("midreset_done", s_fd, 1'b0);
        @(posedge clk); #1;
        s_rst = 1'b0;
        cnt0 = win_cnt[0];
        for (int i = 0; i < 16; i++) begin
            send_s(PW'(i));
            if (i == 10) check("post_reset_first_win", s_wo, FIRST_WIN);
        end
        @(posedge clk); #1;
        check("post_reset_win_count", 32'(win_cnt[0] - cnt0), 32'd4);

        // Clear with a pixel presented while a window is pending.
        for (int i = 0; i <= 10; i++) send_s(PW'(i));
        s_wr = 1'b0;
        s_px = PW'(77);
        s_pv = 1'b1;
        s_clr = 1'b1;
        @(posedge clk); #1;
        s_clr = 1'b0;
        s_pv = 1'b0;
        s_wr = 1'b1;
        check("clear_valid", s_wv, 1'b0);
        check("clear_win", s_wo, '0);
        cnt0 = win_cnt[0];
        for (int i = 0; i < 16; i++) begin
            send_s(PW'(i));
            if (i == 10) check("post_clear_first_win", s_wo, FIRST_WIN);
        end
        @(posedge clk); #1;
        check("post_clear_win_count", 32'(win_cnt[0] - cnt0), 32'd4);

        // Random traffic on the 16x16 instance, three frames.
        cnt0 = win_cnt[1];
        acc = 0;
        cyc = 0;
        while (acc < 768 && cyc < 20000) begin
            b_pv = ($urandom_range(0, 99) < 70);
            b_px = PW'($urandom);
            b_wr = ($urandom_range(0, 99) < 70);
            #1;
            if (b_pv && b_pr) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        b_pv = 1'b0;
        b_wr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("random_pixels_accepted", 32'(acc), 32'd768);
        check("random_win_count", 32'(win_cnt[1] - cnt0), 32'd588);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
